// File: rtl/segre_mem_stage.sv
// segre_mem_stage: EX/MEM stage register, data-memory req/ack access,
// load alignment/extension and the registered write-back payload.
module segre_mem_stage #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned ADDR_SIZE = 32,
    parameter int unsigned REG_SIZE  = 5
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    // EX payload
    input  logic                 valid_ex_i,
    input  logic [WORD_SIZE-1:0] alu_res_i,
    input  logic                 rf_we_i,
    input  logic [REG_SIZE-1:0]  rf_waddr_i,
    input  logic [WORD_SIZE-1:0] rf_st_data_i,
    input  logic [1:0]           memop_type_i,
    input  logic                 memop_rd_i,
    input  logic                 memop_wr_i,
    input  logic                 memop_sign_ext_i,
    input  logic                 inject_nops_i,
    input  logic                 block_mem_i,
    // data memory
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic [3:0]           mem_be_o,
    output logic [WORD_SIZE-1:0] mem_wdata_o,
    input  logic                 mem_ack_i,
    input  logic [WORD_SIZE-1:0] mem_rdata_i,
    // pipeline control / write-back
    output logic                 stall_o,
    output logic                 rf_we_o,
    output logic [REG_SIZE-1:0]  rf_waddr_o,
    output logic [WORD_SIZE-1:0] rf_data_o,
    output logic                 misaligned_o,
    output logic                 valid_mem_o
);

    // memop_data_type_e encoding
    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HELD = 2'd2
    } state_e;

    state_e state_q, state_d;

    // stage register
    logic                 valid_q, valid_d;
    logic [WORD_SIZE-1:0] alu_q, alu_d;
    logic                 we_q, we_d;
    logic [REG_SIZE-1:0]  waddr_q, waddr_d;
    logic [WORD_SIZE-1:0] st_q, st_d;
    logic [1:0]           type_q, type_d;
    logic                 rd_q, rd_d;
    logic                 wr_q, wr_d;
    logic                 sext_q, sext_d;

    // load data captured while write-back was blocked
    logic [WORD_SIZE-1:0] hold_q, hold_d;

    // output register
    logic                 out_valid_q, out_valid_d;
    logic                 out_we_q, out_we_d;
    logic [REG_SIZE-1:0]  out_waddr_q, out_waddr_d;
    logic [WORD_SIZE-1:0] out_data_q, out_data_d;
    logic                 out_mis_q, out_mis_d;

    logic                 is_byte, is_half, is_word;
    logic [1:0]           off;
    logic                 memop, misaligned, aligned_memop, misaligned_memop;
    logic [WORD_SIZE-1:0] rdata_src, lane, load_data;

    // Access decode, memory request signals and load alignment
    always_comb begin
        is_byte          = (type_q == MEM_BYTE);
        is_half          = (type_q == MEM_HALF);
        is_word          = ~is_byte & ~is_half;
        off              = alu_q[1:0];
        memop            = valid_q & (rd_q | wr_q);
        misaligned       = (is_half & off[0]) | (is_word & (off != 2'b00));
        aligned_memop    = memop & ~misaligned;
        misaligned_memop = memop & misaligned;

        mem_req_o  = aligned_memop & (state_q != ST_HELD);
        mem_we_o   = wr_q;
        mem_addr_o = {alu_q[ADDR_SIZE-1:2], 2'b00};

        if (is_byte) begin
            mem_be_o    = 4'b0001 << off;
            mem_wdata_o = {4{st_q[7:0]}};
        end else if (is_half) begin
            mem_be_o    = 4'b0011 << {off[1], 1'b0};
            mem_wdata_o = {2{st_q[15:0]}};
        end else begin
            mem_be_o    = 4'b1111;
            mem_wdata_o = st_q;
        end

        rdata_src = (state_q == ST_HELD) ? hold_q : mem_rdata_i;
        lane      = rdata_src >> {off, 3'b000};
        if (is_byte) begin
            load_data = {{(WORD_SIZE-8){lane[7] & sext_q}}, lane[7:0]};
        end else if (is_half) begin
            load_data = {{(WORD_SIZE-16){lane[15] & sext_q}}, lane[15:0]};
        end else begin
            load_data = lane;
        end

        stall_o = block_mem_i
                | (aligned_memop & ~mem_ack_i & (state_q != ST_HELD))
                | (state_q == ST_HELD);
    end

    // Access FSM next state and hold-register capture
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (aligned_memop) begin
                    if (mem_ack_i) begin
                        if (block_mem_i) begin
                            state_d = ST_HELD;
                            hold_d  = mem_rdata_i;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_HELD: begin
                if (!block_mem_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage register next value; the held access retires on HELD exit
    always_comb begin
        valid_d = valid_q;
        alu_d   = alu_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        st_d    = st_q;
        type_d  = type_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        sext_d  = sext_q;
        if ((state_q == ST_HELD) && !block_mem_i) begin
            // EX is still stalled this cycle, so leave a bubble behind
            valid_d = 1'b0;
            we_d    = 1'b0;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
        end else if (!stall_o) begin
            alu_d   = alu_res_i;
            waddr_d = rf_waddr_i;
            st_d    = rf_st_data_i;
            type_d  = memop_type_i;
            sext_d  = memop_sign_ext_i;
            valid_d = valid_ex_i & ~inject_nops_i;
            we_d    = rf_we_i & ~inject_nops_i;
            rd_d    = memop_rd_i & ~inject_nops_i;
            wr_d    = memop_wr_i & ~inject_nops_i;
        end
    end

    // Write-back payload next value; frozen while write-back is blocked
    always_comb begin
        out_valid_d = out_valid_q;
        out_we_d    = out_we_q;
        out_waddr_d = out_waddr_q;
        out_data_d  = out_data_q;
        out_mis_d   = out_mis_q;
        if (!block_mem_i) begin
            if ((state_q == ST_HELD) || (aligned_memop && mem_ack_i)) begin
                out_valid_d = 1'b1;
                out_we_d    = we_q & ~wr_q;
                out_waddr_d = waddr_q;
                out_data_d  = rd_q ? load_data : alu_q;
                out_mis_d   = 1'b0;
            end else if (aligned_memop) begin
                out_valid_d = 1'b0;
                out_we_d    = 1'b0;
                out_mis_d   = 1'b0;
            end else begin
                out_valid_d = valid_q;
                out_we_d    = valid_q & we_q & ~wr_q & ~misaligned_memop;
                out_waddr_d = waddr_q;
                out_data_d  = alu_q;
                out_mis_d   = misaligned_memop;
            end
        end
    end

    // FSM state and hold register
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // EX/MEM stage register
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            valid_q <= 1'b0;
            alu_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            st_q    <= '0;
            type_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            sext_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            alu_q   <= alu_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            st_q    <= st_d;
            type_q  <= type_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            sext_q  <= sext_d;
        end
    end

    // Write-back output register
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            out_valid_q <= 1'b0;
            out_we_q    <= 1'b0;
            out_waddr_q <= '0;
            out_data_q  <= '0;
            out_mis_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_we_q    <= out_we_d;
            out_waddr_q <= out_waddr_d;
            out_data_q  <= out_data_d;
            out_mis_q   <= out_mis_d;
        end
    end

    assign valid_mem_o  = out_valid_q;
    assign rf_we_o      = out_we_q;
    assign rf_waddr_o   = out_waddr_q;
    assign rf_data_o    = out_data_q;
    assign misaligned_o = out_mis_q;

endmodule

// File: tb/tb_segre_mem_stage.sv
// Bench for segre_mem_stage: directed scenarios plus randomized traffic,
// checked against an architectural model (program-order memory image and
// an in-order queue of expected write-back payloads).
module tb_segre_mem_stage;

    logic        clk_i = 1'b0;
    logic        rsn_i;
    logic        valid_ex_i;
    logic [31:0] alu_res_i;
    logic        rf_we_i;
    logic [4:0]  rf_waddr_i;
    logic [31:0] rf_st_data_i;
    logic [1:0]  memop_type_i;
    logic        memop_rd_i, memop_wr_i, memop_sign_ext_i;
    logic        inject_nops_i, block_mem_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o, rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_data_o;
    logic        misaligned_o, valid_mem_o;

    segre_mem_stage dut (
        .clk_i(clk_i), .rsn_i(rsn_i),
        .valid_ex_i(valid_ex_i), .alu_res_i(alu_res_i), .rf_we_i(rf_we_i),
        .rf_waddr_i(rf_waddr_i), .rf_st_data_i(rf_st_data_i),
        .memop_type_i(memop_type_i), .memop_rd_i(memop_rd_i),
        .memop_wr_i(memop_wr_i), .memop_sign_ext_i(memop_sign_ext_i),
        .inject_nops_i(inject_nops_i), .block_mem_i(block_mem_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
        .rf_data_o(rf_data_o), .misaligned_o(misaligned_o),
        .valid_mem_o(valid_mem_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  waddr;
        logic        we;
        logic        mis;
    } wb_t;

    wb_t         expq[$];
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    int          checks = 0;
    int          errors = 0;

    // EX-side instruction the bench is presenting
    logic        ex_valid, ex_we, ex_rd, ex_wr, ex_sext, inj, blk, rst_drv;
    logic [31:0] ex_alu, ex_st;
    logic [4:0]  ex_waddr;
    logic [1:0]  ex_type;

    // memory responder
    logic        busy;
    int          cnt, lat_force, reqs, aligned_cnt;
    logic [31:0] req_addr;

    // per-cycle samples
    logic        s_req, s_we, s_ack, s_stall, s_valid, s_rfwe, s_mis, prev_blk;
    logic [31:0] s_addr, s_wdata, s_data, p_data;
    logic [3:0]  s_be;
    logic [4:0]  s_waddr;
    logic        p_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_mis(input logic [1:0] t, input logic [31:0] a);
        if (t == 2'd1) return (a % 2) != 0;
        if (t == 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] a,
                                             input logic [1:0] t, input logic sx);
        logic [31:0] v;
        v = word >> (8 * (a % 4));
        if (t == 2'd0) begin
            v = v % 256;
            if (sx && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (t == 2'd1) begin
            v = v % 65536;
            if (sx && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] t, input logic [31:0] st);
        int n, o;
        logic [3:0] idx;
        idx = a[5:2];
        o   = int'(a % 4);
        n   = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
        for (int k = 0; k < n; k++) ref_mem[idx][8*(o+k) +: 8] = st[8*k +: 8];
    endtask

    // Architectural result of the instruction just accepted into the stage
    task automatic accept();
        wb_t e;
        logic [3:0] idx;
        idx     = ex_alu[5:2];
        e.waddr = ex_waddr;
        e.data  = ex_alu;
        e.we    = ex_we;
        e.mis   = 1'b0;
        if (ex_rd || ex_wr) begin
            if (is_mis(ex_type, ex_alu)) begin
                e.we  = 1'b0;
                e.mis = 1'b1;
            end else begin
                aligned_cnt++;
                if (ex_wr) begin
                    ref_store(ex_alu, ex_type, ex_st);
                    e.we = 1'b0;
                end else begin
                    e.data = ref_load(ref_mem[idx], ex_alu, ex_type, ex_sext);
                end
            end
        end
        expq.push_back(e);
    endtask

    task automatic set_ex(input logic [31:0] a, input logic [31:0] st, input logic [1:0] t,
                          input logic rd, input logic wr, input logic sx,
                          input logic we, input logic [4:0] wa);
        ex_valid = 1'b1; ex_alu = a; ex_st = st; ex_type = t;
        ex_rd = rd; ex_wr = wr; ex_sext = sx; ex_we = we; ex_waddr = wa;
    endtask

    // One clock: drive, answer memory, sample/check at negedge, advance
    task automatic cycle();
        wb_t e;
        logic [3:0] idx;
        rsn_i = rst_drv; valid_ex_i = ex_valid; alu_res_i = ex_alu; rf_we_i = ex_we;
        rf_waddr_i = ex_waddr; rf_st_data_i = ex_st; memop_type_i = ex_type;
        memop_rd_i = ex_rd; memop_wr_i = ex_wr; memop_sign_ext_i = ex_sext;
        inject_nops_i = inj; block_mem_i = blk; mem_ack_i = 1'b0;
        #1;
        if (!rsn_i) begin
            busy = 1'b0;
        end else if (mem_req_o) begin
            if (!busy) begin
                busy = 1'b1; reqs++; req_addr = mem_addr_o;
                cnt = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
            end else begin
                chk("req_addr_stable", mem_addr_o, req_addr);
            end
            if (cnt == 0) begin
                mem_ack_i = 1'b1; busy = 1'b0; idx = mem_addr_o[5:2];
                if (mem_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be_o[b]) mem[idx][8*b +: 8] = mem_wdata_o[8*b +: 8];
                end else begin
                    mem_rdata_i = mem[idx];
                end
            end else begin
                cnt--;
                mem_rdata_i = $urandom;
            end
        end else if (busy) begin
            chk("req_held_until_ack", 32'(mem_req_o), 32'd1);
            busy = 1'b0;
        end
        #3;
        s_req = mem_req_o; s_we = mem_we_o; s_addr = mem_addr_o; s_be = mem_be_o;
        s_wdata = mem_wdata_o; s_ack = mem_ack_i; s_stall = stall_o; s_valid = valid_mem_o;
        s_rfwe = rf_we_o; s_waddr = rf_waddr_o; s_data = rf_data_o; s_mis = misaligned_o;
        if (!rsn_i) begin
            expq.delete();
            prev_blk = 1'b0;
        end else begin
            if (prev_blk) begin
                chk("wb_frozen_valid", 32'(s_valid), 32'(p_valid));
                chk("wb_frozen_data", s_data, p_data);
            end else if (s_valid) begin
                if (expq.size() == 0) begin
                    chk("wb_unexpected_valid", 32'(s_valid), 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("wb_data", s_data, e.data);
                    chk("wb_waddr", 32'(s_waddr), 32'(e.waddr));
                    chk("wb_we", 32'(s_rfwe), 32'(e.we));
                    chk("wb_mis", 32'(s_mis), 32'(e.mis));
                end
            end else begin
                chk("bubble_we", 32'(s_rfwe), 32'd0);
            end
            if (!s_stall && ex_valid && !inj) begin
                accept();
                ex_valid = 1'b0;
            end
            prev_blk = blk;
        end
        p_valid = s_valid; p_data = s_data;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int n_req, n_stall, r0;
        rst_drv = 1'b0; ex_valid = 1'b0; inj = 1'b0; blk = 1'b0;
        ex_alu = '0; ex_st = '0; ex_type = '0; ex_rd = 1'b0; ex_wr = 1'b0;
        ex_sext = 1'b0; ex_we = 1'b0; ex_waddr = '0; mem_rdata_i = '0;
        busy = 1'b0; cnt = 0; lat_force = -1; reqs = 0; aligned_cnt = 0;
        req_addr = '0; prev_blk = 1'b0; p_valid = 1'b0; p_data = '0;
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        @(posedge clk_i); #1;

        // reset state
        cycle(); cycle();
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_rf_we", 32'(s_rfwe), 32'd0);
        chk("rst_mis", 32'(s_mis), 32'd0);
        chk("rst_req", 32'(s_req), 32'd0);
        chk("rst_stall", 32'(s_stall), 32'd0);
        rst_drv = 1'b1;

        // ALU op passes one cycle after stage capture
        set_ex(32'h0000_1234, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
        cycle();
        cycle(); chk("alu_no_req", 32'(s_req), 32'd0);
        cycle();
        chk("alu_valid", 32'(s_valid), 32'd1);
        chk("alu_data", s_data, 32'h0000_1234);
        chk("alu_waddr", 32'(s_waddr), 32'd5);
        chk("alu_we", 32'(s_rfwe), 32'd1);

        // LB 0x1003 signed, three wait cycles
        mem[0] = 32'h80FF_FFFF; ref_mem[0] = 32'h80FF_FFFF;
        set_ex(32'h0000_1003, 32'h0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7);
        lat_force = 3;
        cycle();
        n_req = 0; n_stall = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (s_req && !s_ack) n_req++;
            if (s_stall) n_stall++;
            if (s_req) begin
                chk("lb_addr", s_addr, 32'h0000_1000);
                chk("lb_be", 32'(s_be), 32'h8);
            end
            if (s_ack) break;
        end
        chk("lb_acked", 32'(s_ack), 32'd1);
        chk("lb_req_wait_cycles", 32'(n_req), 32'd3);
        chk("lb_stall_cycles", 32'(n_stall), 32'd3);
        cycle();
        chk("lb_sext_data", s_data, 32'hFFFF_FF80);

        // LBU same address, zero-wait
        set_ex(32'h0000_1003, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8);
        lat_force = 0;
        cycle(); cycle(); cycle();
        chk("lbu_data", s_data, 32'h0000_0080);

        // SH 0x2002 zero-wait
        set_ex(32'h0000_2002, 32'hABCD_1234, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9);
        cycle(); cycle();
        chk("sh_req", 32'(s_req), 32'd1);
        chk("sh_we", 32'(s_we), 32'd1);
        chk("sh_be", 32'(s_be), 32'hC);
        chk("sh_wdata", s_wdata, 32'h1234_1234);
        chk("sh_stall", 32'(s_stall), 32'd0);
        cycle();
        chk("sh_valid", 32'(s_valid), 32'd1);
        chk("sh_rf_we", 32'(s_rfwe), 32'd0);

        // misaligned LW 0x3001
        set_ex(32'h0000_3001, 32'h0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 5'd10);
        cycle(); cycle();
        chk("mis_no_req", 32'(s_req), 32'd0);
        cycle();
        chk("mis_flag", 32'(s_mis), 32'd1);
        chk("mis_rf_we", 32'(s_rfwe), 32'd0);
        chk("mis_valid", 32'(s_valid), 32'd1);

        // LW acked while write-back blocked
        mem[1] = 32'hDEAD_BEEF; ref_mem[1] = 32'hDEAD_BEEF;
        set_ex(32'h0000_0044, 32'h0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 5'd11);
        cycle();
        r0 = reqs; blk = 1'b1;
        cycle();
        chk("held_ack_req", 32'(s_req), 32'd1);
        chk("held_ack_stall", 32'(s_stall), 32'd1);
        cycle();
        chk("held_no_req", 32'(s_req), 32'd0);
        chk("held_stall", 32'(s_stall), 32'd1);
        blk = 1'b0;
        cycle();
        chk("held_release_req", 32'(s_req), 32'd0);
        chk("held_release_stall", 32'(s_stall), 32'd1);
        cycle();
        chk("held_data", s_data, 32'hDEAD_BEEF);
        chk("held_valid", 32'(s_valid), 32'd1);
        chk("held_one_req", 32'(reqs - r0), 32'd1);

        // reset while waiting for ack
        lat_force = 10;
        set_ex(32'h0000_0048, 32'h0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 5'd12);
        cycle(); cycle();
        chk("wait_req", 32'(s_req), 32'd1);
        cycle();
        rst_drv = 1'b0; cycle(); rst_drv = 1'b1;
        lat_force = -1;
        cycle();
        chk("rst_wait_req", 32'(s_req), 32'd0);
        chk("rst_wait_valid", 32'(s_valid), 32'd0);
        chk("rst_wait_stall", 32'(s_stall), 32'd0);
        set_ex(32'h0000_0055, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3);
        cycle(); cycle(); cycle();
        chk("post_rst_alu_data", s_data, 32'h0000_0055);
        chk("post_rst_alu_valid", 32'(s_valid), 32'd1);

        // randomized traffic
        reqs = 0; aligned_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!ex_valid && ($urandom % 4) != 0) begin
                int kind;
                kind = int'($urandom % 4);
                set_ex(32'($urandom_range(0, 63)), $urandom, 2'($urandom % 3),
                       kind == 1, kind == 2, 1'($urandom % 2),
                       (kind == 2) ? 1'($urandom % 2) : 1'b1, 5'($urandom));
            end
            inj = (($urandom % 10) == 0);
            blk = (($urandom % 5) == 0);
            cycle();
        end
        ex_valid = 1'b0; inj = 1'b0; blk = 1'b0;
        repeat (12) cycle();
        chk("drain_empty", 32'(expq.size()), 32'd0);
        chk("one_req_per_memop", 32'(reqs), 32'(aligned_cnt));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
